// File: rtl/axis_uart_tx_arbiter_if.sv
// Bundle of AXI-Stream lanes. N parallel lanes share one interface instance:
// lane i uses tvalid[i], tlast[i], tready[i] and tdata[i*DATA_W +: DATA_W].
// The producer side takes the master modport, the consumer side the slave modport.
interface axis_uart_tx_arbiter_if #(
  parameter int N      = 1,
  parameter int DATA_W = 8
);
  logic [N-1:0]        tvalid;
  logic [N*DATA_W-1:0] tdata;
  logic [N-1:0]        tlast;
  logic [N-1:0]        tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one AXI-Stream UART TX among
// NUM_SRC producer streams. A grant is held until the source's tlast beat or
// until MAX_BEATS beats have been sent. On a forced release m_tlast is raised
// on the last beat.
// Optional feature: define AXIS_UART_ARB_TAG_EN to send one header byte
// (TAG_BASE + grant) ahead of every granted packet.
module axis_uart_tx_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 64
`ifdef AXIS_UART_ARB_TAG_EN
  ,
  parameter logic [DATA_W-1:0] TAG_BASE = DATA_W'(8'hF0)
`endif
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  axis_uart_tx_arbiter_if.slave      s_axis,
  axis_uart_tx_arbiter_if.master     m_axis,
  output logic [$clog2(NUM_SRC)-1:0] grant,
  output logic                       busy
);

  localparam int GW = $clog2(NUM_SRC);
  localparam int CW = $clog2(MAX_BEATS + 1);

`ifdef AXIS_UART_ARB_TAG_EN
  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_TAG  = 2'd1,
    ST_PASS = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_PASS = 2'd2
  } state_t;
`endif

  state_t              state_r;
  logic [GW-1:0]       grant_r;
  logic [GW-1:0]       last_grant_r;
  logic [CW-1:0]       beat_cnt_r;
  logic                busy_r;

  logic [2*NUM_SRC-1:0] rot_s;
  int                   pick_off_s;
  int                   pick_sum_s;
  logic                 pick_valid_s;
  logic [GW-1:0]        pick_idx_s;

  logic                 sel_valid_s;
  logic [DATA_W-1:0]    sel_data_s;
  logic                 sel_last_s;

  logic                 force_s;
  logic                 beat_s;
  logic                 release_s;

  logic                 m_tvalid_s;
  logic [DATA_W-1:0]    m_tdata_s;
  logic                 m_tlast_s;
  logic [NUM_SRC-1:0]   s_tready_s;

  // Round-robin pick: rotate the request vector so the source after the last
  // grant sits at bit 0, take the lowest set bit, then map back to an index.
  always_comb begin
    rot_s        = {s_axis.tvalid, s_axis.tvalid} >> (int'(last_grant_r) + 1);
    pick_off_s   = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      pick_off_s = rot_s[k] ? k : pick_off_s;
    end
    pick_valid_s = |s_axis.tvalid;
    pick_sum_s   = int'(last_grant_r) + 1 + pick_off_s;
    pick_idx_s   = GW'((pick_sum_s >= NUM_SRC) ? (pick_sum_s - NUM_SRC) : pick_sum_s);
  end

  // Select the granted source's valid/data/last using constant lane indices.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_data_s  = '0;
    sel_last_s  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_valid_s = (grant_r == GW'(i)) ? s_axis.tvalid[i] : sel_valid_s;
      sel_data_s  = (grant_r == GW'(i)) ? s_axis.tdata[i*DATA_W +: DATA_W] : sel_data_s;
      sel_last_s  = (grant_r == GW'(i)) ? s_axis.tlast[i] : sel_last_s;
    end
  end

  assign force_s   = (beat_cnt_r == CW'(MAX_BEATS - 1));
  assign beat_s    = (state_r == ST_PASS) & sel_valid_s & m_axis.tready[0];
  assign release_s = beat_s & (sel_last_s | force_s);

  // Output steering: idle in ARB, header byte in TAG, granted lane in PASS.
  always_comb begin
    m_tvalid_s = 1'b0;
    m_tdata_s  = '0;
    m_tlast_s  = 1'b0;
    s_tready_s = '0;
    case (state_r)
      ST_ARB: begin
        m_tvalid_s = 1'b0;
      end
`ifdef AXIS_UART_ARB_TAG_EN
      ST_TAG: begin
        m_tvalid_s = 1'b1;
        m_tdata_s  = TAG_BASE + DATA_W'(grant_r);
      end
`endif
      ST_PASS: begin
        m_tvalid_s = sel_valid_s;
        m_tdata_s  = sel_data_s;
        m_tlast_s  = sel_last_s | force_s;
        for (int i = 0; i < NUM_SRC; i++) begin
          s_tready_s[i] = (grant_r == GW'(i)) ? m_axis.tready[0] : 1'b0;
        end
      end
      default: begin
        m_tvalid_s = 1'b0;
      end
    endcase
  end

  assign m_axis.tvalid = m_tvalid_s;
  assign m_axis.tdata  = m_tdata_s;
  assign m_axis.tlast  = m_tlast_s;
  assign s_axis.tready = s_tready_s;
  assign grant         = grant_r;
  assign busy          = busy_r;

  // Arbitration FSM: grant, beat counting, release and the busy flag.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r      <= ST_ARB;
      grant_r      <= '0;
      last_grant_r <= GW'(NUM_SRC - 1);
      beat_cnt_r   <= '0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_ARB: begin
          if (pick_valid_s) begin
            grant_r    <= pick_idx_s;
            busy_r     <= 1'b1;
            beat_cnt_r <= '0;
`ifdef AXIS_UART_ARB_TAG_EN
            state_r    <= ST_TAG;
`else
            state_r    <= ST_PASS;
`endif
          end
        end
`ifdef AXIS_UART_ARB_TAG_EN
        ST_TAG: begin
          if (m_axis.tready[0]) begin
            state_r <= ST_PASS;
          end
        end
`endif
        ST_PASS: begin
          if (beat_s) begin
            beat_cnt_r <= (beat_cnt_r == CW'(MAX_BEATS)) ? beat_cnt_r : beat_cnt_r + CW'(1);
            if (release_s) begin
              last_grant_r <= grant_r;
              busy_r       <= 1'b0;
              state_r      <= ST_ARB;
            end
          end
        end
        default: begin
          state_r <= ST_ARB;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
